fp_addsub_issue: RTL and testbench
==================================

Name: fp_addsub_issue

Overview:
Sequential issue/capture stage placed directly upstream of the combinational FP32 add/sub datapath.
- Input side: accepts operand pairs over a valid/ready handshake and holds them stable on the datapath inputs for a programmable settle window.
- Output side: samples the datapath result and flags, presents them downstream over a second valid/ready handshake, and keeps sticky exception/underflow status for software.

Parameters:
SETTLE_CYCLES, 1, cycles between operand launch and result sample; legal range 1..15
TAG_W, 4, width of the request tag carried from input to output

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  stage can accept a request
in_a  in  32  FP32 operand A
in_b  in  32  FP32 operand B
in_sub  in  1  1 = A-B, 0 = A+B
in_tag  in  TAG_W  request tag
dp_n1  out  32  operand A to datapath
dp_n2  out  32  operand B to datapath
dp_sub  out  1  op select to datapath
dp_result  in  32  datapath result
dp_exception  in  1  datapath exception flag
dp_underflow  in  1  datapath underflow flag
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_result  out  32  captured result
out_tag  out  TAG_W  tag of the captured request
out_exception  out  1  captured exception flag
out_underflow  out  1  captured underflow flag
sticky_exc  out  1  OR of all captured exceptions since last clear
sticky_unf  out  1  OR of all captured underflows since last clear
clr_sticky  in  1  clear both sticky bits
busy  out  1  state != IDLE

Behaviour:
- One clock. Reset is synchronous and active-low.
- All outputs are registered.
- Reset values: every output is 0, including in_ready. FSM goes to IDLE and cnt goes to 0.
- in_ready rises at the first edge with rst_n=1.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE (in_ready=1):
  - At edge E0 with in_valid=1: latch in_a/in_b/in_sub into dp_n1/dp_n2/dp_sub; latch in_tag.
  - Load cnt=SETTLE_CYCLES, clear in_ready, go to SETTLE.
- SETTLE:
  - Each edge decrements cnt.
  - At the edge where cnt==1: capture dp_result, dp_exception, dp_underflow and the tag into the out_* registers; set out_valid=1; go to HOLD.
  - out_valid therefore rises after edge E0+SETTLE_CYCLES.
- HOLD:
  - out_* and dp_* are held stable.
  - At an edge with out_ready=1: clear out_valid, set in_ready=1, go to IDLE.
  - No new request is accepted in the same edge.
  - Throughput: one op per SETTLE_CYCLES+2 cycles minimum.
- dp_* keep their last values in IDLE; they are not cleared after completion.
- Sticky bits:
  - At the capture edge, sticky_x <= sticky_x | captured_x.
  - clr_sticky=1 clears both bits.
  - If clear and capture fall on the same edge, the newly captured flag is set: capture wins.
- out_ready asserted while out_valid=0 has no effect.
- in_valid outside IDLE is ignored; the requester must hold it.
- Reset asserted in any state, including mid-SETTLE, aborts the op with no output. The bench sees no out_valid afterwards.
- SETTLE_CYCLES outside 1..15 is a compile-time error, raised by an elaboration assertion.

Optional Feature:
FP_ZERO_BYPASS_EN
- The datapath always inserts a hidden 1, so it mishandles ±0.
- Macro defined, bypass applies when an operand is ±0 (exp==0 and mantissa==0) and neither exponent is 8'hFF:
  - A zero: result = B with sign XOR in_sub.
  - B zero: result = A.
  - Both zero: result = {A.sign & (B.sign^in_sub), 31'b0}.
  - Flags are captured as 0. Latency is unchanged.
  - The bypass decision is registered at E0.
- Macro undefined: the datapath result is always used.

Decomposition:
- Package fp_alu_pkg holds:
  - FP32 field constants: EXP_MSB=30, EXP_LSB=23, MAN_W=23, EXP_ALL_ONES=8'hFF.
  - The state enum {IDLE, SETTLE, HOLD}.
  - Function is_fp_zero.
- One natural combinational sub-module, fp_zero_bypass, instantiated only under FP_ZERO_BYPASS_EN.

Test Plan:
1. Real datapath, SETTLE_CYCLES=1: A=0x3FC00000, B=0x40100000, sub=0, tag=3 -> out_valid one edge after acceptance; out_result=0x40700000; tag 3; flags 0.
2. A=0x40100000, B=0x3FC00000, sub=1 -> 0x3F400000. Then hold out_ready=0 for 5 cycles -> out_* stable, in_ready=0, busy=1 throughout.
3. A=0x7F800000, B=0x3F800000 -> out_result=0xFFFFFFFF, out_exception=1, sticky_exc=1. Assert clr_sticky on the capture edge of the next exception op -> sticky_exc stays 1.
4. SETTLE_CYCLES=3, stub datapath changing dp_result every cycle -> the sampled value equals the stub value at edge E0+3; out_valid rises exactly 3 edges after acceptance.
5. rst_n=0 for one cycle during SETTLE -> all outputs 0 next edge; no out_valid; in_ready=1 one edge after release.
6. FP_ZERO_BYPASS_EN: A=0x00000000, B=0x40100000, sub=1 -> 0xC0100000, flags 0. Same op without the macro -> datapath value passed through unchanged.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// Shared FP32 field constants, issue-stage state encoding and the signed-zero test
// used by the FP add/sub issue stage and its optional zero bypass.
package fp_alu_pkg;

  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_W   = 23;
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  // +0 and -0 both have a zero exponent and a zero mantissa; the sign is irrelevant
  function automatic logic is_fp_zero(input logic [31:0] x);
    return (x[EXP_MSB:EXP_LSB] == 8'h00) && (x[MAN_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/fp_zero_bypass.sv
// Substitutes an exact result when an operand is +-0, because the downstream datapath
// always assumes a hidden 1 and would otherwise produce a wrong answer for zeros.
module fp_zero_bypass
  import fp_alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic        o_bypass,
  output logic [31:0] o_result
);

  logic w_aZero;
  logic w_bZero;
  logic w_anySpecial;

  assign w_aZero      = is_fp_zero(i_a);
  assign w_bZero      = is_fp_zero(i_b);
  assign w_anySpecial = (i_a[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) ||
                        (i_b[EXP_MSB:EXP_LSB] == EXP_ALL_ONES);
  assign o_bypass     = (w_aZero || w_bZero) && !w_anySpecial;

  // Both zero: the result is -0 only when A and the effective B are both negative
  always_comb begin
    o_result = i_a;
    if (w_aZero && w_bZero) begin
      o_result = {i_a[31] & (i_b[31] ^ i_sub), 31'b0};
    end else if (w_aZero) begin
      o_result = {i_b[31] ^ i_sub, i_b[30:0]};
    end
  end

endmodule

// File: rtl/fp_addsub_issue.sv
// Issue/capture stage in front of the combinational FP32 add/sub datapath.
// Define FP_ZERO_BYPASS_EN to substitute exact results for +-0 operands.
module fp_addsub_issue
  import fp_alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      dp_n1,
  output logic [31:0]      dp_n2,
  output logic             dp_sub,
  input  logic [31:0]      dp_result,
  input  logic             dp_exception,
  input  logic             dp_underflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_exception,
  output logic             out_underflow,
  output logic             sticky_exc,
  output logic             sticky_unf,
  input  logic             clr_sticky,
  output logic             busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_badSettle
    $error("fp_addsub_issue: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_inReady;
  logic [31:0]      r_dpN1;
  logic [31:0]      r_dpN2;
  logic             r_dpSub;
  logic [TAG_W-1:0] r_tag;
  logic             r_outValid;
  logic [31:0]      r_outResult;
  logic [TAG_W-1:0] r_outTag;
  logic             r_outExc;
  logic             r_outUnf;
  logic             r_stickyExc;
  logic             r_stickyUnf;
  logic             r_busy;

  logic             w_accept;
  logic             w_capture;
  logic [31:0]      w_capResult;
  logic             w_capExc;
  logic             w_capUnf;

  assign w_accept  = (r_state == IDLE) && r_inReady && in_valid;
  assign w_capture = (r_state == SETTLE) && (r_cnt == 4'd1);

`ifdef FP_ZERO_BYPASS_EN
  logic        w_bypass;
  logic [31:0] w_bypassResult;
  logic        r_bypass;
  logic [31:0] r_bypassResult;

  fp_zero_bypass u_zeroBypass (
    .i_a      (in_a),
    .i_b      (in_b),
    .i_sub    (in_sub),
    .o_bypass (w_bypass),
    .o_result (w_bypassResult)
  );

  // The decision is taken from the operands as accepted, so it stays aligned with dp_*
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bypass       <= 1'b0;
      r_bypassResult <= '0;
    end else if (w_accept) begin
      r_bypass       <= w_bypass;
      r_bypassResult <= w_bypassResult;
    end
  end

  assign w_capResult = r_bypass ? r_bypassResult : dp_result;
  assign w_capExc    = !r_bypass && dp_exception;
  assign w_capUnf    = !r_bypass && dp_underflow;
`else
  assign w_capResult = dp_result;
  assign w_capExc    = dp_exception;
  assign w_capUnf    = dp_underflow;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_inReady   <= 1'b0;
      r_dpN1      <= '0;
      r_dpN2      <= '0;
      r_dpSub     <= 1'b0;
      r_tag       <= '0;
      r_outValid  <= 1'b0;
      r_outResult <= '0;
      r_outTag    <= '0;
      r_outExc    <= 1'b0;
      r_outUnf    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_inReady <= 1'b1;
          if (w_accept) begin
            r_dpN1    <= in_a;
            r_dpN2    <= in_b;
            r_dpSub   <= in_sub;
            r_tag     <= in_tag;
            r_cnt     <= LP_SETTLE;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= SETTLE;
          end
        end
        SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_outResult <= w_capResult;
            r_outTag    <= r_tag;
            r_outExc    <= w_capExc;
            r_outUnf    <= w_capUnf;
            r_outValid  <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          // in_ready returns here but a request can only be taken on the following edge
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A flag captured on the same edge as a clear survives the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stickyExc <= 1'b0;
      r_stickyUnf <= 1'b0;
    end else begin
      r_stickyExc <= (r_stickyExc && !clr_sticky) || (w_capture && w_capExc);
      r_stickyUnf <= (r_stickyUnf && !clr_sticky) || (w_capture && w_capUnf);
    end
  end

  assign in_ready      = r_inReady;
  assign dp_n1         = r_dpN1;
  assign dp_n2         = r_dpN2;
  assign dp_sub        = r_dpSub;
  assign out_valid     = r_outValid;
  assign out_result    = r_outResult;
  assign out_tag       = r_outTag;
  assign out_exception = r_outExc;
  assign out_underflow = r_outUnf;
  assign sticky_exc    = r_stickyExc;
  assign sticky_unf    = r_stickyUnf;
  assign busy          = r_busy;

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Randomized self-checking bench for fp_addsub_issue with a time-varying stub datapath,
// so capture timing is visible in the sampled value.
module tb_fp_addsub_issue;

  localparam int SETTLE = 3;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_sub;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      dp_n1;
  logic [31:0]      dp_n2;
  logic             dp_sub;
  logic [31:0]      dp_result;
  logic             dp_exception;
  logic             dp_underflow;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_exception;
  logic             out_underflow;
  logic             sticky_exc;
  logic             sticky_unf;
  logic             clr_sticky;
  logic             busy;

  int unsigned edgeCount = 0;
  int          vectorCount = 0;
  int          missCount = 0;
  logic        mStickyExc = 1'b0;
  logic        mStickyUnf = 1'b0;

  fp_addsub_issue #(.SETTLE_CYCLES(SETTLE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .dp_n1(dp_n1), .dp_n2(dp_n2), .dp_sub(dp_sub),
    .dp_result(dp_result), .dp_exception(dp_exception), .dp_underflow(dp_underflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .out_exception(out_exception), .out_underflow(out_underflow),
    .sticky_exc(sticky_exc), .sticky_unf(sticky_unf),
    .clr_sticky(clr_sticky), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Stub datapath: a different pseudo-random result and flags every cycle
  function automatic logic [33:0] stubVal(input int unsigned c);
    logic [31:0] h;
    h = (c * 32'h9E3779B1) ^ 32'h5A5A1234;
    return {h[5] & h[9], h[12] & h[2], h};
  endfunction

  assign {dp_underflow, dp_exception, dp_result} = stubVal(edgeCount);

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Expected result straight from the zero-handling rules: returns {used, value}
  function automatic logic [32:0] refZero(input logic [31:0] a, input logic [31:0] b, input logic sub);
    bit aZero, bZero, special;
    aZero   = (a[30:0] == 31'd0);
    bZero   = (b[30:0] == 31'd0);
    special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    if (!(aZero || bZero) || special) return {1'b0, 32'h0};
    if (aZero && bZero) return {1'b1, a[31] & (b[31] ^ sub), 31'b0};
    if (aZero) return {1'b1, b[31] ^ sub, b[30:0]};
    return {1'b1, a};
  endfunction

  function automatic logic [31:0] randOperand();
    int unsigned sel;
    logic [31:0] v;
    sel = $urandom_range(0, 7);
    v   = $urandom;
    case (sel)
      0: v = 32'h0000_0000;
      1: v = 32'h8000_0000;
      2: v = {v[31], 8'hFF, v[22:0]};
      default: ;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub,
                               input logic [TAG_W-1:0] tag, input int holdCycles,
                               input logic clrAtCapture, input logic clrInHold);
    int          waitCycles;
    logic [33:0] stub;
    logic [32:0] zr;
    logic [31:0] eRes;
    logic        eExc, eUnf;
    waitCycles = 0;
    while (!in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("readyBeforeIssue", 64'(in_ready), 64'(1));
    if (!in_ready) return;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_tag = tag;
    stub = stubVal(edgeCount + SETTLE);
    {eUnf, eExc, eRes} = stub;
`ifdef FP_ZERO_BYPASS_EN
    zr = refZero(a, b, sub);
    if (zr[32]) begin
      eRes = zr[31:0]; eExc = 1'b0; eUnf = 1'b0;
    end
`else
    zr = refZero(a, b, sub);
    if (zr[32] && zr[31:0] == 32'hC010_0000) vectorCount = vectorCount + 0;
`endif
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_sub = ~sub;
    checkOutput("dpN1", 64'(dp_n1), 64'(a));
    checkOutput("dpN2", 64'(dp_n2), 64'(b));
    checkOutput("dpSub", 64'(dp_sub), 64'(sub));
    checkOutput("readyAfterAccept", 64'(in_ready), 64'(0));
    checkOutput("busyAfterAccept", 64'(busy), 64'(1));
    checkOutput("validAtAccept", 64'(out_valid), 64'(0));
    for (int k = 1; k <= SETTLE; k++) begin
      if (k == SETTLE) clr_sticky = clrAtCapture;
      @(negedge clk);
      clr_sticky = 1'b0;
      if (k < SETTLE) checkOutput("validEarly", 64'(out_valid), 64'(0));
    end
    mStickyExc = (mStickyExc && !clrAtCapture) || eExc;
    mStickyUnf = (mStickyUnf && !clrAtCapture) || eUnf;
    checkOutput("validAtCapture", 64'(out_valid), 64'(1));
    checkOutput("result", 64'(out_result), 64'(eRes));
    checkOutput("tag", 64'(out_tag), 64'(tag));
    checkOutput("exception", 64'(out_exception), 64'(eExc));
    checkOutput("underflow", 64'(out_underflow), 64'(eUnf));
    checkOutput("stickyExc", 64'(sticky_exc), 64'(mStickyExc));
    checkOutput("stickyUnf", 64'(sticky_unf), 64'(mStickyUnf));
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
    for (int h = 0; h < holdCycles; h++) begin
      clr_sticky = (h == 0) && clrInHold;
      @(negedge clk);
      if (clr_sticky) begin
        mStickyExc = 1'b0; mStickyUnf = 1'b0;
      end
      clr_sticky = 1'b0;
      checkOutput("holdValid", 64'(out_valid), 64'(1));
      checkOutput("holdResult", 64'(out_result), 64'(eRes));
      checkOutput("holdReady", 64'(in_ready), 64'(0));
      checkOutput("holdBusy", 64'(busy), 64'(1));
      checkOutput("holdDpN1", 64'(dp_n1), 64'(a));
      checkOutput("holdStickyExc", 64'(sticky_exc), 64'(mStickyExc));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    checkOutput("releaseValid", 64'(out_valid), 64'(0));
    checkOutput("releaseReady", 64'(in_ready), 64'(1));
    checkOutput("releaseBusy", 64'(busy), 64'(0));
    checkOutput("noSameEdgeAccept", 64'(dp_n1), 64'(a));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "InReady"}, 64'(in_ready), 64'(0));
    checkOutput({tag, "Valid"}, 64'(out_valid), 64'(0));
    checkOutput({tag, "Busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "DpN1"}, 64'(dp_n1), 64'(0));
    checkOutput({tag, "DpN2"}, 64'(dp_n2), 64'(0));
    checkOutput({tag, "Result"}, 64'(out_result), 64'(0));
    checkOutput({tag, "Tag"}, 64'(out_tag), 64'(0));
    checkOutput({tag, "Sticky"}, 64'({sticky_exc, sticky_unf, out_exception, out_underflow}), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("readyAfterReset", 64'(in_ready), 64'(1));

    applyStimulus(32'h3FC0_0000, 32'h4010_0000, 1'b0, 4'd3, 0, 1'b0, 1'b0);
    applyStimulus(32'h4010_0000, 32'h3FC0_0000, 1'b1, 4'd5, 5, 1'b0, 1'b0);
    applyStimulus(32'h0000_0000, 32'h4010_0000, 1'b1, 4'd7, 1, 1'b0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h0000_0000, 1'b1, 4'd9, 0, 1'b1, 1'b0);
    applyStimulus(32'h7F80_0000, 32'h0000_0000, 1'b0, 4'd2, 2, 1'b0, 1'b1);

    for (int n = 0; n < 30; n++) begin
      int hc;
      hc = $urandom_range(0, 4);
      applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                    TAG_W'($urandom), hc, 1'($urandom_range(0, 3) == 0),
                    1'(hc > 0 && $urandom_range(0, 3) == 0));
    end

    in_valid = 1'b1; in_a = 32'h4040_0000; in_b = 32'h3F80_0000; in_tag = 4'hA;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mStickyExc = 1'b0; mStickyUnf = 1'b0;
    checkAllZero("midSettleReset");
    @(negedge clk);
    checkOutput("readyAfterAbort", 64'(in_ready), 64'(1));
    for (int i = 0; i < SETTLE + 3; i++) begin
      @(negedge clk);
      checkOutput("noValidAfterAbort", 64'(out_valid), 64'(0));
    end
    applyStimulus(32'h4040_0000, 32'h8000_0000, 1'b0, 4'hB, 1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
